qspi_arb: RTL and testbench
===========================

Name: qspi_arb

Overview:
- Parametrised N-port arbiter between the line-fill/write-back requesters (icache, dcache, future DMA/debug) and the single qspi engine.
- Replaces the fixed two-way ifetch/dcache tag and request mux in the top level.
- Adds round-robin or fixed-priority selection with anti-starvation aging, a registered per-transaction context, and steering of data-beat strobes to the owning requester.

Parameters:
- NREQ, 3, number of requester ports (2..8); port 0 is highest priority in fixed mode.
- PA, 22, physical address width.
- LINE_LENGTH, 4, cache line length in bytes; TW = PA - clog2(LINE_LENGTH) is the tag width.
- RR, 1, 1 = round-robin arbitration, 0 = fixed priority with aging.
- AGE_MAX, 15, fixed mode only: lost arbitrations before a waiting port is forced to win.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low (0 = in reset)
- req  in  NREQ  per-port transfer request, level, held until done
- wr  in  NREQ  per-port: 1 = line write-back, 0 = line fill
- mem  in  NREQ  per-port: 1 = ROM/flash space, 0 = RAM space
- tag  in  NREQ*TW  per-port line tag, port i at [i*TW +: TW]
- grant  out  NREQ  one-hot owner of current transaction, registered
- done  out  NREQ  one-cycle completion pulse to the owner
- beat  out  NREQ  q_beat steered to the owner, combinational
- q_req  out  1  request to qspi
- q_write  out  1  registered wr of owner
- q_mem  out  1  registered mem of owner
- q_tag  out  TW  registered tag of owner
- q_ack  in  1  qspi accepted request (one cycle)
- q_beat  in  1  qspi data-beat strobe (read or write nibble)
- q_done  in  1  qspi transfer complete (one cycle)

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - grant, done, q_req, q_write, q_mem and q_tag all go to 0.
  - RR pointer goes to 0 and all age counters clear.
  - Reset is asynchronous, so q_req drops immediately, including mid-transfer.
- IDLE:
  - If any req is high, select a winner.
  - Load grant, q_write, q_mem and q_tag from the winner.
  - Next cycle: state ISSUE with q_req = 1.
  - Latency from req to q_req is 1 cycle.
- Winner selection:
  - RR=1: the first requesting port at or after the pointer, searching upward with wrap-around modulo NREQ.
  - RR=0: if any port's age == AGE_MAX, the lowest-index such port wins; otherwise the lowest-index requesting port wins.
- ISSUE:
  - q_req is held at 1.
  - q_ack -> XFER, and q_req drops in the next cycle.
  - If the owner's req drops before q_ack (abort, e.g. fault): state returns to IDLE, grant clears, no done pulse.
  - q_ack and req-drop in the same cycle: q_ack wins and the transaction goes to XFER.
- XFER:
  - beat[owner] = q_beat; all other beat bits are 0.
  - Changes to the owner's req, wr, mem or tag are ignored; context stays frozen.
  - q_done -> DONE.
  - A q_beat in the same cycle as q_done is still steered to the owner.
- DONE:
  - done[owner] = 1 for exactly this cycle, then grant clears.
  - RR=1: pointer advances to owner+1 (mod NREQ).
  - Next state is IDLE, which always lasts at least 1 cycle. This gives the owner time to drop req.
  - The same port may win again only by normal arbitration.
- Aging (RR=0):
  - On every IDLE arbitration, each requesting non-winner increments its age, saturating at AGE_MAX.
  - The winner's age clears.
  - Non-requesting ports clear their age.
- Invariants:
  - grant is one-hot or zero.
  - done and beat are non-zero only for the granted bit.
  - q_ack, q_beat and q_done outside their valid states are ignored.
- Write-back then fill:
  - The requester issues these as two separate transactions.
  - The arbiter gives no atomicity guarantee between them.

Test Plan:
- Single port: req[1]=1, wr=0, tag=0x1234 in IDLE -> cycle+1: grant=3'b010, q_req=1, q_tag=0x1234, q_write=0. Then q_ack; 8 q_beat pulses -> 8 beat[1] pulses, beat[0]=beat[2]=0. Then q_done -> done[1] for one cycle, then grant=0.
- Round-robin, RR=1: req=3'b111 held, each transaction completed with q_ack/q_done -> grant order 0,1,2,0. After each done, exactly one cycle with q_req=0 before the next q_req.
- Fixed priority, RR=0, AGE_MAX=2: req=3'b101 continuously, port 0 re-requests each time -> port 0 wins twice, port 2 wins the third arbitration, then port 0 again.
- Abort: req[2] drops in ISSUE before q_ack -> next cycle IDLE, grant=0, no done. Same-cycle q_ack and req drop -> XFER continues and done[2] is pulsed.
- Frozen context: in XFER, change tag[0] from 0x0100 to 0x0200 and wr[0] from 1 to 0 -> q_tag stays 0x0100 and q_write stays 1 until done.
- Reset mid-XFER: reset=0 -> q_req, grant, done and beat go to 0 asynchronously. After release, arbitration restarts with RR pointer 0 and all ages 0.

Source files
------------

// File: rtl/qspi_arb.sv
// qspi_arb: N-port arbiter in front of the single qspi engine.
// Picks an owner (round-robin, or fixed priority with aging), freezes its context and steers beats/done back.
module qspi_arb #(
  parameter int NREQ        = 3,
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4,
  parameter int RR          = 1,
  parameter int AGE_MAX     = 15,
  localparam int TW         = PA - $clog2(LINE_LENGTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    wr,
  input  logic [NREQ-1:0]    mem,
  input  logic [NREQ*TW-1:0] tag,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    beat,
  output logic               q_req,
  output logic               q_write,
  output logic               q_mem,
  output logic [TW-1:0]      q_tag,
  input  logic               q_ack,
  input  logic               q_beat,
  input  logic               q_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
  localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [NREQ-1:0]          grant_q, grant_d;
  logic                     wr_q, wr_d;
  logic                     mem_q, mem_d;
  logic [TW-1:0]            tag_q, tag_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [NREQ-1:0][AW-1:0]  age_q, age_d;

  logic [IW-1:0]            win_idx;
  logic                     win_found;
  logic [IW-1:0]            owner_idx;

  // Winner: two passes give "first at or after ptr, wrapping" (RR) or "aged first, then lowest index".
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    if (RR != 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && req[i] && (IW'(i) >= ptr_q)) begin
          win_idx   = IW'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && req[i] && (age_q[i] == AGE_SAT)) begin
          win_idx   = IW'(i);
          win_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i]) begin
        win_idx   = IW'(i);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner_idx = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    mem_d   = mem_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    age_d   = age_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d          = S_ISSUE;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          wr_d             = wr[win_idx];
          mem_d            = mem[win_idx];
          tag_d            = tag[win_idx*TW +: TW];
          if (RR == 0) begin
            for (int i = 0; i < NREQ; i++) begin
              if ((IW'(i) == win_idx) || !req[i]) begin
                age_d[i] = '0;
              end else if (age_q[i] != AGE_SAT) begin
                age_d[i] = age_q[i] + 1'b1;
              end
            end
          end
        end
      end
      S_ISSUE: begin
        // An ack in the same cycle as the owner dropping req still commits the transfer.
        if (q_ack) begin
          state_d = S_XFER;
        end else if ((req & grant_q) == '0) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_XFER: begin
        if (q_done) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        if (RR != 0) begin
          ptr_d = (int'(owner_idx) == NREQ - 1) ? '0 : owner_idx + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      wr_q    <= 1'b0;
      mem_q   <= 1'b0;
      tag_q   <= '0;
      ptr_q   <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      mem_q   <= mem_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
      age_q   <= age_d;
    end
  end

  assign grant   = grant_q;
  assign q_req   = (state_q == S_ISSUE);
  assign q_write = wr_q;
  assign q_mem   = mem_q;
  assign q_tag   = tag_q;
  assign done    = (state_q == S_DONE) ? grant_q : '0;
  assign beat    = (state_q == S_XFER) ? (grant_q & {NREQ{q_beat}}) : '0;

endmodule

// File: tb/tb_qspi_arb.sv
// Bench for qspi_arb: a round-robin instance and a fixed-priority (AGE_MAX=2) instance, each checked
// every cycle against a transaction-level model, plus directed scenarios and randomized traffic.
module tb_qspi_arb;

  localparam int NREQ   = 3;
  localparam int PA     = 22;
  localparam int LL     = 4;
  localparam int TW     = PA - $clog2(LL);
  localparam int TAGW   = NREQ * TW;
  localparam int AGE_FP = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][NREQ-1:0] req_s, wr_s, mem_s, grant_s, done_s, beat_s;
  logic [1:0][TAGW-1:0] tag_s;
  logic [1:0][TW-1:0]   q_tag_s;
  logic [1:0]           q_req_s, q_write_s, q_mem_s, q_ack_s, q_beat_s, q_done_s;

  qspi_arb #(.NREQ(NREQ), .PA(PA), .LINE_LENGTH(LL), .RR(1), .AGE_MAX(15)) u_rr (
    .clk(clk), .reset(reset), .req(req_s[0]), .wr(wr_s[0]), .mem(mem_s[0]), .tag(tag_s[0]),
    .grant(grant_s[0]), .done(done_s[0]), .beat(beat_s[0]), .q_req(q_req_s[0]),
    .q_write(q_write_s[0]), .q_mem(q_mem_s[0]), .q_tag(q_tag_s[0]),
    .q_ack(q_ack_s[0]), .q_beat(q_beat_s[0]), .q_done(q_done_s[0]));

  qspi_arb #(.NREQ(NREQ), .PA(PA), .LINE_LENGTH(LL), .RR(0), .AGE_MAX(AGE_FP)) u_fp (
    .clk(clk), .reset(reset), .req(req_s[1]), .wr(wr_s[1]), .mem(mem_s[1]), .tag(tag_s[1]),
    .grant(grant_s[1]), .done(done_s[1]), .beat(beat_s[1]), .q_req(q_req_s[1]),
    .q_write(q_write_s[1]), .q_mem(q_mem_s[1]), .q_tag(q_tag_s[1]),
    .q_ack(q_ack_s[1]), .q_beat(q_beat_s[1]), .q_done(q_done_s[1]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: owner (-1 = none) plus which part of the transaction it is in.
  int              m_owner [2] = '{-1, -1};
  bit              m_wait  [2] = '{0, 0};
  bit              m_xfer  [2] = '{0, 0};
  bit              m_fin   [2] = '{0, 0};
  int              m_ptr   [2] = '{0, 0};
  int              m_age   [2][NREQ];
  logic [TW-1:0]   m_tag   [2];
  logic            m_wr    [2];
  logic            m_mem   [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_wait[d] = 0; m_xfer[d] = 0; m_fin[d] = 0; m_ptr[d] = 0;
      m_tag[d] = '0; m_wr[d] = 1'b0; m_mem[d] = 1'b0;
      for (int i = 0; i < NREQ; i++) m_age[d][i] = 0;
    end
  endfunction

  function automatic int pick(input int d);
    int w = -1;
    if (d == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr[d] + k) % NREQ;
        if (w < 0 && req_s[d][idx]) w = idx;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) if (w < 0 && req_s[d][i] && m_age[d][i] == AGE_FP) w = i;
      for (int i = 0; i < NREQ; i++) if (w < 0 && req_s[d][i]) w = i;
    end
    return w;
  endfunction

  function automatic void model_step(input int d);
    int w;
    if (m_fin[d]) begin
      if (d == 0) m_ptr[d] = (m_owner[d] + 1) % NREQ;
      m_fin[d]   = 0;
      m_owner[d] = -1;
    end else if (m_owner[d] < 0) begin
      if (req_s[d] != '0) begin
        w = pick(d);
        if (d == 1) begin
          for (int i = 0; i < NREQ; i++) begin
            if (i == w || !req_s[d][i]) m_age[d][i] = 0;
            else if (m_age[d][i] < AGE_FP) m_age[d][i] = m_age[d][i] + 1;
          end
        end
        m_owner[d] = w;
        m_wait[d]  = 1;
        m_tag[d]   = tag_s[d][w*TW +: TW];
        m_wr[d]    = wr_s[d][w];
        m_mem[d]   = mem_s[d][w];
      end
    end else if (m_wait[d]) begin
      if (q_ack_s[d]) begin
        m_wait[d] = 0;
        m_xfer[d] = 1;
      end else if (!req_s[d][m_owner[d]]) begin
        m_wait[d]  = 0;
        m_owner[d] = -1;
      end
    end else if (m_xfer[d] && q_done_s[d]) begin
      m_xfer[d] = 0;
      m_fin[d]  = 1;
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  string           nm [2] = '{"rr", "fp"};
  logic [NREQ-1:0] prev_grant [2] = '{'0, '0};
  int              glog0[$];
  int              glog1[$];
  int              gap [2];

  function automatic int ohidx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic compare_all();
    logic [NREQ-1:0] eg;
    #1;
    for (int d = 0; d < 2; d++) begin
      eg = (m_owner[d] >= 0) ? NREQ'(1 << m_owner[d]) : '0;
      check_eq({nm[d], ".grant"}, 64'(grant_s[d]), 64'(eg));
      check_eq({nm[d], ".q_req"}, 64'(q_req_s[d]), 64'(m_owner[d] >= 0 && m_wait[d]));
      check_eq({nm[d], ".done"}, 64'(done_s[d]), 64'(m_fin[d] ? eg : '0));
      check_eq({nm[d], ".beat"}, 64'(beat_s[d]), 64'((m_xfer[d] && q_beat_s[d]) ? eg : '0));
      if (m_owner[d] >= 0) begin
        check_eq({nm[d], ".q_tag"}, 64'(q_tag_s[d]), 64'(m_tag[d]));
        check_eq({nm[d], ".q_write"}, 64'(q_write_s[d]), 64'(m_wr[d]));
        check_eq({nm[d], ".q_mem"}, 64'(q_mem_s[d]), 64'(m_mem[d]));
      end
      if (grant_s[d] != '0 && grant_s[d] != prev_grant[d]) begin
        if (d == 0) glog0.push_back(ohidx(grant_s[d]));
        else        glog1.push_back(ohidx(grant_s[d]));
      end
      prev_grant[d] = grant_s[d];
    end
  endtask

  task automatic next();
    compare_all();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit coin(input int n);
    return ($urandom_range(n - 1) == 0);
  endfunction

  task automatic drive_rand(input int d);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_s[d][i])                        req_s[d][i] = coin(4);
      else if (m_owner[d] == i && m_fin[d])    req_s[d][i] = coin(2);
      else if (m_owner[d] == i && coin(12))    req_s[d][i] = 1'b0;
    end
    wr_s[d]     = NREQ'($urandom);
    mem_s[d]    = NREQ'($urandom);
    tag_s[d]    = TAGW'({$urandom, $urandom});
    q_ack_s[d]  = m_wait[d] ? coin(2) : coin(8);
    q_beat_s[d] = coin(2);
    q_done_s[d] = m_xfer[d] ? coin(3) : coin(8);
  endtask

  task automatic drain();
    req_s = '0; q_ack_s = '0; q_beat_s = '0; q_done_s = '1;
    repeat (4) next();
    q_done_s = '0;
  endtask

  int exp_rr [4] = '{0, 1, 2, 0};
  int exp_fp [4] = '{0, 0, 2, 0};
  int cnt1, cnto;

  initial begin
    req_s = '0; wr_s = '0; mem_s = '0; tag_s = '0;
    q_ack_s = '0; q_beat_s = '0; q_done_s = '0;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq({nm[d], ".rst_grant"}, 64'(grant_s[d]), 64'd0);
      check_eq({nm[d], ".rst_q_req"}, 64'(q_req_s[d]), 64'd0);
      check_eq({nm[d], ".rst_q_tag"}, 64'(q_tag_s[d]), 64'd0);
      check_eq({nm[d], ".rst_q_write"}, 64'(q_write_s[d]), 64'd0);
      check_eq({nm[d], ".rst_done"}, 64'(done_s[d]), 64'd0);
    end
    reset = 1'b1;
    next();

    // Arbitration order: RR with all ports requesting, fixed priority with ports 0 and 2.
    glog0.delete(); glog1.delete();
    gap = '{-1, -1};
    req_s[0] = 3'b111;
    req_s[1] = 3'b101;
    for (int c = 0; c < 18; c++) begin
      for (int d = 0; d < 2; d++) begin
        q_ack_s[d]  = q_req_s[d];
        q_done_s[d] = m_xfer[d];
        if (gap[d] >= 0) begin
          if (q_req_s[d]) begin
            check_eq({nm[d], ".idle_gap"}, 64'(gap[d]), 64'd1);
            gap[d] = -1;
          end else gap[d]++;
        end
        if (done_s[d] != '0) gap[d] = 0;
      end
      next();
    end
    check_eq("rr.n_grants", 64'(glog0.size() >= 4), 64'd1);
    check_eq("fp.n_grants", 64'(glog1.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr.order%0d", i), 64'(i < glog0.size() ? glog0[i] : -1), 64'(exp_rr[i]));
      check_eq($sformatf("fp.order%0d", i), 64'(i < glog1.size() ? glog1[i] : -1), 64'(exp_fp[i]));
    end
    drain();

    // Single port with beats, including a beat coincident with q_done.
    req_s[0] = 3'b010; wr_s[0] = '0; tag_s[0] = '0;
    tag_s[0][TW +: TW] = 20'h1234;
    next();
    check_eq("sp.grant", 64'(grant_s[0]), 64'b010);
    check_eq("sp.q_req", 64'(q_req_s[0]), 64'd1);
    check_eq("sp.q_tag", 64'(q_tag_s[0]), 64'h1234);
    check_eq("sp.q_write", 64'(q_write_s[0]), 64'd0);
    q_ack_s[0] = 1'b1;
    next();
    q_ack_s[0] = 1'b0;
    check_eq("sp.q_req_after_ack", 64'(q_req_s[0]), 64'd0);
    cnt1 = 0; cnto = 0;
    for (int c = 0; c < 16; c++) begin
      q_beat_s[0] = (c % 2 == 0);
      #1;
      cnt1 += int'(beat_s[0][1]);
      cnto += int'(beat_s[0][0]) + int'(beat_s[0][2]);
      next();
    end
    check_eq("sp.beat1_count", 64'(cnt1), 64'd8);
    check_eq("sp.beat_other_count", 64'(cnto), 64'd0);
    q_done_s[0] = 1'b1; q_beat_s[0] = 1'b1;
    #1 check_eq("sp.beat_with_done", 64'(beat_s[0]), 64'b010);
    next();
    q_done_s[0] = 1'b0; q_beat_s[0] = 1'b0;
    check_eq("sp.done", 64'(done_s[0]), 64'b010);
    req_s[0] = '0;
    next();
    check_eq("sp.done_cleared", 64'(done_s[0]), 64'd0);
    check_eq("sp.grant_cleared", 64'(grant_s[0]), 64'd0);

    // Abort in ISSUE, then ack coinciding with the req drop.
    req_s[0] = 3'b100;
    next();
    check_eq("ab.grant", 64'(grant_s[0]), 64'b100);
    req_s[0] = '0;
    next();
    check_eq("ab.grant_cleared", 64'(grant_s[0]), 64'd0);
    check_eq("ab.q_req_cleared", 64'(q_req_s[0]), 64'd0);
    next();
    check_eq("ab.no_done", 64'(done_s[0]), 64'd0);
    req_s[0] = 3'b100;
    next();
    req_s[0] = '0; q_ack_s[0] = 1'b1;
    next();
    q_ack_s[0] = 1'b0;
    check_eq("ab2.grant_held", 64'(grant_s[0]), 64'b100);
    q_done_s[0] = 1'b1;
    next();
    q_done_s[0] = 1'b0;
    check_eq("ab2.done", 64'(done_s[0]), 64'b100);
    next();

    // Context frozen during XFER.
    req_s[0] = 3'b001; wr_s[0] = 3'b001;
    tag_s[0][0 +: TW] = 20'h0100;
    next();
    q_ack_s[0] = 1'b1;
    next();
    q_ack_s[0] = 1'b0;
    tag_s[0][0 +: TW] = 20'h0200; wr_s[0] = 3'b000;
    next();
    check_eq("fz.q_tag", 64'(q_tag_s[0]), 64'h0100);
    check_eq("fz.q_write", 64'(q_write_s[0]), 64'd1);
    q_done_s[0] = 1'b1;
    next();
    q_done_s[0] = 1'b0;
    check_eq("fz.done", 64'(done_s[0]), 64'b001);
    check_eq("fz.q_tag_at_done", 64'(q_tag_s[0]), 64'h0100);
    check_eq("fz.q_write_at_done", 64'(q_write_s[0]), 64'd1);
    req_s[0] = '0;
    next();

    // Asynchronous reset in XFER; pointer must restart from 0 afterwards.
    req_s[0] = 3'b001;
    next();
    q_ack_s[0] = 1'b1;
    next();
    q_ack_s[0] = 1'b0; q_beat_s[0] = 1'b1;
    #1 check_eq("ar.beat_before", 64'(beat_s[0]), 64'b001);
    #2 reset = 1'b0;
    #1;
    check_eq("ar.q_req", 64'(q_req_s[0]), 64'd0);
    check_eq("ar.grant", 64'(grant_s[0]), 64'd0);
    check_eq("ar.done", 64'(done_s[0]), 64'd0);
    check_eq("ar.beat", 64'(beat_s[0]), 64'd0);
    req_s[0] = 3'b101; q_beat_s[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    next();
    check_eq("ar.ptr_restart", 64'(grant_s[0]), 64'b001);
    drain();

    // Randomized traffic on both instances, with one reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      drive_rand(0);
      drive_rand(1);
      if (c == 1500) #2 reset = 1'b0;
      if (c == 1502) reset = 1'b1;
      next();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
